// File: rtl/dm_responder_if.sv
// Load/store channel between the M-stage of the core and the data-memory responder.
// The master is the core; the slave is dm_responder.
interface dm_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;
  logic        req_ready;
  logic        stall_m;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        wlog_valid;
  logic [31:0] wlog_pc;
  logic [31:0] wlog_addr;
  logic [31:0] wlog_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
    input  req_ready, stall_m, resp_valid, resp_rdata, resp_err,
    input  wlog_valid, wlog_pc, wlog_addr, wlog_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, req_pc,
    output req_ready, stall_m, resp_valid, resp_rdata, resp_err,
    output wlog_valid, wlog_pc, wlog_addr, wlog_data
  );
endinterface

// File: rtl/dm_responder.sv
// Multi-cycle data-memory responder: accepts one held request, waits LATENCY cycles,
// performs the word access and returns a single response pulse plus a store log record.
module dm_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic          clk,
  input  logic          reset,
  dm_responder_if.slave bus
);

  localparam int          IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH_WORDS) * 64'd4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;
  logic [31:0] pc_q;
  logic [31:0] mem_q [DEPTH_WORDS];
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic        wlog_valid_q;
  logic [31:0] wlog_pc_q;
  logic [31:0] wlog_addr_q;
  logic [31:0] wlog_data_q;

  logic             err_d;
  logic [IDX_W-1:0] idx_d;
  logic [31:0]      merged_d;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

  // Request check on the live bus; the full 32-bit compare means no wrap-around into range.
  always_comb begin
    err_d    = (bus.req_addr[1:0] != 2'b00) ||
               ({32'd0, bus.req_addr} >= ADDR_LIMIT);
    idx_d    = addr_q[IDX_W+1:2];
    merged_d = merge_bytes(mem_q[idx_d], wdata_q, be_q);
  end

  // Request FSM, memory array and registered response/log outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      addr_q       <= 32'd0;
      wdata_q      <= 32'd0;
      be_q         <= 4'd0;
      pc_q         <= 32'd0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= 32'd0;
      wlog_valid_q <= 1'b0;
      wlog_pc_q    <= 32'd0;
      wlog_addr_q  <= 32'd0;
      wlog_data_q  <= 32'd0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        mem_q[i] <= 32'd0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          wlog_valid_q <= 1'b0;
          if (bus.req_valid) begin
            we_q    <= bus.req_we;
            addr_q  <= bus.req_addr;
            wdata_q <= bus.req_wdata;
            be_q    <= bus.req_be;
            pc_q    <= bus.req_pc;
            if (err_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else begin
              state_q <= S_WAIT;
              cnt_q   <= 4'(LATENCY);
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            if (we_q) begin
              mem_q[idx_d] <= merged_d;
              wlog_valid_q <= 1'b1;
              wlog_pc_q    <= pc_q;
              wlog_addr_q  <= {addr_q[31:2], 2'b00};
              wlog_data_q  <= merged_d;
            end else begin
              resp_rdata_q <= mem_q[idx_d];
            end
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            state_q      <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          wlog_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
        default: begin
          resp_valid_q <= 1'b0;
          resp_err_q   <= 1'b0;
          wlog_valid_q <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_q == S_IDLE);
  assign bus.stall_m    = bus.req_valid && (state_q != S_RESP);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_err   = resp_err_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.wlog_valid = wlog_valid_q;
  assign bus.wlog_pc    = wlog_pc_q;
  assign bus.wlog_addr  = wlog_addr_q;
  assign bus.wlog_data  = wlog_data_q;

endmodule

// File: tb/tb_dm_responder.sv
// Directed bench for dm_responder: three instances (LATENCY 0, 2, 3) share one request driver.
module tb_dm_responder;

  logic        clk;
  logic        reset;
  logic [1:0]  sel;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic [31:0] req_pc;

  logic [2:0]  ready_a, stall_a, rv_a, rerr_a, wv_a;
  logic [31:0] rdata_a [3];
  logic [31:0] wpc_a   [3];
  logic [31:0] waddr_a [3];
  logic [31:0] wdata_a [3];

  int n_checks;
  int n_errors;

  logic        r_err, r_wv;
  logic [31:0] r_rdata, r_wpc, r_waddr, r_wdata;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    dm_responder_if u_bus ();

    assign u_bus.req_valid = req_valid && (sel == 2'(g));
    assign u_bus.req_we    = req_we;
    assign u_bus.req_addr  = req_addr;
    assign u_bus.req_wdata = req_wdata;
    assign u_bus.req_be    = req_be;
    assign u_bus.req_pc    = req_pc;

    assign ready_a[g] = u_bus.req_ready;
    assign stall_a[g] = u_bus.stall_m;
    assign rv_a[g]    = u_bus.resp_valid;
    assign rerr_a[g]  = u_bus.resp_err;
    assign wv_a[g]    = u_bus.wlog_valid;
    assign rdata_a[g] = u_bus.resp_rdata;
    assign wpc_a[g]   = u_bus.wlog_pc;
    assign waddr_a[g] = u_bus.wlog_addr;
    assign wdata_a[g] = u_bus.wlog_data;

    dm_responder #(
      .DEPTH_WORDS(1024),
      .LATENCY    ((g == 0) ? 0 : ((g == 1) ? 2 : 3))
    ) u_dut (
      .clk  (clk),
      .reset(reset),
      .bus  (u_bus)
    );
  end

  wire        ready = ready_a[sel];
  wire        stall = stall_a[sel];
  wire        rv    = rv_a[sel];
  wire        rerr  = rerr_a[sel];
  wire        wv    = wv_a[sel];
  wire [31:0] rdata = rdata_a[sel];
  wire [31:0] wpc   = wpc_a[sel];
  wire [31:0] waddr = waddr_a[sel];
  wire [31:0] wdata = wdata_a[sel];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge of the following IDLE cycle.
  task automatic send(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [3:0] be, input logic [31:0] pc,
                      input bit drop, input int exp_lat);
    int edges;
    bit stall_ok;
    bit ready_ok;
    check_eq("ready_idle", {31'd0, ready}, 32'd1);
    req_we = we; req_addr = addr; req_wdata = wd; req_be = be; req_pc = pc;
    req_valid = 1'b1;
    edges = 0; stall_ok = 1'b1; ready_ok = 1'b1;
    while (edges < 40) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (drop && edges == 1) begin
        req_valid = 1'b0;
        req_addr  = addr + 32'd4;
        req_wdata = ~wd;
      end
      if (rv) break;
      if (!drop && !stall) stall_ok = 1'b0;
      if (ready) ready_ok = 1'b0;
    end
    check_eq("latency", 32'(edges), 32'(exp_lat));
    check_eq("stall_hold", {31'd0, stall_ok}, 32'd1);
    check_eq("ready_low", {31'd0, ready_ok}, 32'd1);
    check_eq("stall_resp", {31'd0, stall}, 32'd0);
    r_err = rerr; r_wv = wv; r_rdata = rdata;
    r_wpc = wpc; r_waddr = waddr; r_wdata = wdata;
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("pulse_once", {31'd0, rv}, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rv"},    {31'd0, rv},   32'd0);
    check_eq({tag, "_err"},   {31'd0, rerr}, 32'd0);
    check_eq({tag, "_rdata"}, rdata,         32'd0);
    check_eq({tag, "_wv"},    {31'd0, wv},   32'd0);
    check_eq({tag, "_wpc"},   wpc,           32'd0);
    check_eq({tag, "_waddr"}, waddr,         32'd0);
    check_eq({tag, "_wdata"}, wdata,         32'd0);
    check_eq({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check_eq({tag, "_ready"}, {31'd0, ready}, 32'd1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    sel = 2'd1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
    req_wdata = 32'd0; req_be = 4'd0; req_pc = 32'd0;
    reset = 1'b0;
    #1;
    check_all_zero("rst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Store then load, LATENCY=2.
    send(1'b1, 32'h10, 32'h12345678, 4'b1111, 32'h3000, 1'b0, 4);
    check_eq("st1_err", {31'd0, r_err}, 32'd0);
    check_eq("st1_wv", {31'd0, r_wv}, 32'd1);
    check_eq("st1_wpc", r_wpc, 32'h3000);
    check_eq("st1_waddr", r_waddr, 32'h10);
    check_eq("st1_wdata", r_wdata, 32'h12345678);
    send(1'b0, 32'h10, 32'h0, 4'b0000, 32'h3004, 1'b0, 4);
    check_eq("ld1_rdata", r_rdata, 32'h12345678);
    check_eq("ld1_err", {31'd0, r_err}, 32'd0);
    check_eq("ld1_wv", {31'd0, r_wv}, 32'd0);

    // Byte merge on lane 1.
    send(1'b1, 32'h10, 32'h0000AB00, 4'b0010, 32'h3008, 1'b0, 4);
    check_eq("bm_wdata", r_wdata, 32'h1234AB78);
    check_eq("bm_wpc", r_wpc, 32'h3008);
    send(1'b0, 32'h10, 32'h0, 4'b0000, 32'h300C, 1'b0, 4);
    check_eq("bm_rdata", r_rdata, 32'h1234AB78);

    // Errors: misaligned, out of range, wrap-around address.
    send(1'b0, 32'h11, 32'h0, 4'b0000, 32'h3010, 1'b0, 1);
    check_eq("mis_err", {31'd0, r_err}, 32'd1);
    check_eq("mis_rdata_hold", r_rdata, 32'h1234AB78);
    send(1'b1, 32'h1000, 32'h55555555, 4'b1111, 32'h3014, 1'b0, 1);
    check_eq("oor_err", {31'd0, r_err}, 32'd1);
    check_eq("oor_wv", {31'd0, r_wv}, 32'd0);
    check_eq("oor_wdata_hold", r_wdata, 32'h1234AB78);
    send(1'b0, 32'hFFFF_FFFC, 32'h0, 4'b0000, 32'h3018, 1'b0, 1);
    check_eq("wrap_err", {31'd0, r_err}, 32'd1);
    send(1'b0, 32'h0FFC, 32'h0, 4'b0000, 32'h301C, 1'b0, 4);
    check_eq("top_err", {31'd0, r_err}, 32'd0);
    check_eq("top_rdata", r_rdata, 32'h0);

    // be=0000 still responds and logs, memory untouched.
    send(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h3020, 1'b0, 4);
    check_eq("be0_wv", {31'd0, r_wv}, 32'd1);
    check_eq("be0_wdata", r_wdata, 32'h1234AB78);
    send(1'b0, 32'h10, 32'h0, 4'b0000, 32'h3024, 1'b0, 4);
    check_eq("be0_rdata", r_rdata, 32'h1234AB78);

    // Reset during WAIT of a store.
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'hFFFFFFFF;
    req_be = 4'b1111; req_pc = 32'h3028; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("pre_rst_ready", {31'd0, ready}, 32'd0);
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check_all_zero("midrst");
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send(1'b0, 32'h30, 32'h0, 4'b0000, 32'h302C, 1'b0, 4);
    check_eq("rst_mem30", r_rdata, 32'h0);
    send(1'b0, 32'h10, 32'h0, 4'b0000, 32'h3030, 1'b0, 4);
    check_eq("rst_mem10", r_rdata, 32'h0);

    // LATENCY=0, back-to-back store/load.
    sel = 2'd0;
    #1;
    send(1'b1, 32'h20, 32'hDEADBEEF, 4'b1111, 32'h4000, 1'b0, 2);
    check_eq("l0_wdata", r_wdata, 32'hDEADBEEF);
    send(1'b0, 32'h20, 32'h0, 4'b0000, 32'h4004, 1'b0, 2);
    check_eq("l0_rdata", r_rdata, 32'hDEADBEEF);

    // LATENCY=3, request dropped and scrambled after accept.
    sel = 2'd2;
    #1;
    send(1'b1, 32'h40, 32'hCAFEF00D, 4'b1111, 32'h5000, 1'b0, 5);
    send(1'b1, 32'h44, 32'h11223344, 4'b1111, 32'h5004, 1'b0, 5);
    send(1'b0, 32'h40, 32'h0, 4'b0000, 32'h5008, 1'b1, 5);
    check_eq("drop_rdata", r_rdata, 32'hCAFEF00D);
    check_eq("drop_err", {31'd0, r_err}, 32'd0);
    @(negedge clk);
    check_eq("drop_no_extra", {31'd0, rv}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dm_responder.md
Name: dm_responder

Overview:
- Multi-cycle data-memory responder on the far end of the pipeline's M-stage load/store interface.
- The core presents one request and holds it. The block accepts it, waits a programmable latency, then performs the access and returns one response pulse.
- Drives a stall back to the core while a request is outstanding.
- Emits a write-log record per successful store for the grading display.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words; valid byte addresses 0 .. 4*DEPTH_WORDS-1
LATENCY, 2, extra wait cycles before the access is performed (0..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (asserted when 0)
req_valid  input  1  M-stage memory request present
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data, already byte-lane aligned
req_be  input  4  byte enables for store; bit i selects wdata[8i+7:8i]
req_pc  input  32  PC of the requesting instruction (for the log)
req_ready  output  1  high only in IDLE
stall_m  output  1  freeze F/D/E/M registers
resp_valid  output  1  one-cycle response pulse
resp_rdata  output  32  full word read; byte/half extraction is done by the core
resp_err  output  1  valid with resp_valid; misaligned or out-of-range request
wlog_valid  output  1  pulses with resp_valid on a successful store
wlog_pc  output  32  latched req_pc
wlog_addr  output  32  latched address with bits [1:0] forced to 0
wlog_data  output  32  memory word after the byte-merge

Behaviour:
- Reset (reset==0, asynchronous), applied immediately:
  - state=IDLE, counter=0.
  - All memory words cleared to 0.
  - resp_valid=0, resp_err=0, resp_rdata=0, wlog_valid=0, wlog_pc=0, wlog_addr=0, wlog_data=0.
  - Reset mid-operation aborts the request; a pending store never updates memory.
- FSM states:
  - IDLE: req_ready=1. On an edge with req_valid=1, latch we/addr/wdata/be/pc.
    - Error if req_addr[1:0]!=0, or req_addr >= 4*DEPTH_WORDS. On error go to RESP with err=1; no memory access is made.
    - Otherwise go to WAIT with counter=LATENCY.
  - WAIT: if counter==0, perform the access and go to RESP; else counter decrements.
    - Store: for each be[i]=1, update byte i of mem[addr[31:2]]. be=0000 leaves memory unchanged but still responds.
    - Load: capture mem[addr[31:2]] into resp_rdata.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
    - resp_err is meaningful only while resp_valid=1; otherwise 0.
- Latency:
  - Good request: resp_valid is high in the cycle following the (LATENCY+2)th rising edge after (and including) the accept edge. With LATENCY=2, accept at edge 0 gives resp_valid in the cycle after edge 3.
  - Error request: resp_valid in the cycle after the accept edge + 1.
- stall_m = req_valid && state!=RESP (combinational):
  - The core advances on the edge that ends the RESP cycle.
  - Back-to-back requests are therefore accepted at the earliest on the cycle after RESP, which is IDLE.
- Changes to req_* after the accept edge are ignored. A req_valid drop during WAIT does not cancel the request; the response is still issued.
- resp_rdata holds its last load value until the next successful load. Stores and errors do not change it.
- Write log:
  - wlog_valid=1 only in the RESP cycle of a non-error store.
  - wlog_pc, wlog_addr and wlog_data are updated at the access edge and hold their values afterwards.
- Address arithmetic:
  - Word index = addr[31:2].
  - The range check uses the full 32-bit comparison, with no wrap; 32'hFFFF_FFFC is out of range.

Test Plan:
1. Store then load, LATENCY=2, pc=0x3000: store addr=0x10, wdata=0x12345678, be=1111.
   - resp_valid 3 edges after the accept edge; wlog = {0x3000, 0x10, 0x12345678}; stall_m high until RESP.
   - A following load of 0x10 returns resp_rdata=0x12345678, resp_err=0.
2. Byte merge: word 0x10=0x12345678; store wdata=0x0000AB00, be=0010.
   - wlog_data=0x1234AB78; a later load returns 0x1234AB78.
3. Errors: load addr=0x11 -> resp_err=1 one cycle after accept, no WAIT. Store addr=0x1000 (DEPTH 1024) -> resp_err=1, wlog_valid=0, memory unchanged.
4. LATENCY=0 with back-to-back store/load to 0x20 (wdata=0xDEADBEEF):
   - Each response arrives 1 edge after accept; req_ready is low during WAIT/RESP.
   - The load returns 0xDEADBEEF.
5. Reset mid-WAIT of store 0x30 <- 0xFFFFFFFF: pull reset low during WAIT.
   - All outputs are 0 immediately; state is IDLE.
   - After release, a load of 0x30 returns 0x00000000.
6. req_valid dropped after accept (LATENCY=3): the response still pulses once at the normal latency; the data is from the originally latched address.
